// File: rtl/branch_hazard_unit.sv
// branch_hazard_unit: decodes fetched control-flow instructions, stalls fetch until resolution, flushes on taken
module branch_hazard_unit #(
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 64,
  parameter bit SC_IS_BRANCH = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  input  logic [31:0]       inst,
  input  logic [PC_W-1:0]   pc,
  input  logic              br_resolved,
  input  logic              br_taken,
  output logic              stall_fetch,
  output logic              flush,
  output logic              pending_valid,
  output logic [PC_W-1:0]   pending_pc,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);
  localparam int WW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FLUSH_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_RES, FLUSH} state_t;
  state_t            r_state, w_next;
  logic [WW-1:0]     r_wcnt;
  logic [FW-1:0]     r_fcnt;
  logic              r_stall, r_flush, r_pv, r_eto, r_esp;
  logic [PC_W-1:0]   r_ppc;
  logic [CNT_W-1:0]  r_bc, r_tc;
  logic [5:0]        w_op;
  logic [9:0]        w_xo;
  logic              w_is_br, w_detect, w_res_t, w_res_n, w_tmo, w_fdone, w_unused;
  assign w_op     = inst[31:26];
  assign w_xo     = inst[10:1];
  assign w_unused = ^{inst[25:11], inst[0]};
  assign w_is_br  = w_op == 6'd16 || w_op == 6'd18 ||
                    (w_op == 6'd19 && (w_xo == 10'd16 || w_xo == 10'd528)) ||
                    (SC_IS_BRANCH && w_op == 6'd17);
  // Next-state selection; the resolution term is checked before the timeout so it wins on a tie
  always_comb begin
    w_detect = r_state == IDLE && inst_valid && w_is_br;
    w_res_t  = r_state == WAIT_RES && br_resolved && br_taken;
    w_res_n  = r_state == WAIT_RES && br_resolved && !br_taken;
    w_tmo    = r_state == WAIT_RES && !br_resolved && r_wcnt == WW'(TIMEOUT - 1);
    w_fdone  = r_state == FLUSH && r_fcnt == FW'(FLUSH_CYCLES - 1);
    w_next   = w_detect ? WAIT_RES :
               w_res_t  ? FLUSH :
               (w_res_n || w_tmo || w_fdone) ? IDLE : r_state;
  end
  // State, counters and registered outputs; reset aborts any in-flight branch without a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_fcnt  <= '0;
      r_stall <= 1'b0;
      r_flush <= 1'b0;
      r_pv    <= 1'b0;
      r_ppc   <= '0;
      r_eto   <= 1'b0;
      r_esp   <= 1'b0;
      r_bc    <= '0;
      r_tc    <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= r_state == WAIT_RES ? r_wcnt + 1'b1 : '0;
      r_fcnt  <= r_state == FLUSH ? r_fcnt + 1'b1 : '0;
      r_stall <= w_next != IDLE;
      r_pv    <= w_next != IDLE;
      r_flush <= w_next == FLUSH;
      if (w_detect) r_ppc <= pc;
      if (w_tmo) r_eto <= 1'b1;
      if (br_resolved && r_state != WAIT_RES) r_esp <= 1'b1;
      if (w_detect && !(&r_bc)) r_bc <= r_bc + 1'b1;
      if (w_res_t && !(&r_tc)) r_tc <= r_tc + 1'b1;
    end
  end
  assign stall_fetch   = r_stall;
  assign flush         = r_flush;
  assign pending_valid = r_pv;
  assign pending_pc    = r_ppc;
  assign err_timeout   = r_eto;
  assign err_spurious  = r_esp;
  assign branch_cnt    = r_bc;
  assign taken_cnt     = r_tc;
endmodule
